switch_debounce4: RTL and testbench
===================================

// Module: switch_debounce4
//
// PURPOSE
//   Input-conditioning stage feeding the 4-input combinational decoder (a,b,c,d -> x,y).
//   Synchronises four raw board switches to clk and debounces each one independently.
//   Presents clean registered levels a,b,c,d plus a one-cycle change strobe.
//   Optional auto-scan mode steps the decoder through all 16 input codes without a human.
//
// PARAMETERS
//   CNT_MAX   12000       stable cycles required before a channel updates (1 ms @ 12 MHz)
//   CNT_W     14          debounce counter width; must satisfy 2**CNT_W > CNT_MAX
//   SCAN_DIV  12000000    cycles per auto-scan step (1 s @ 12 MHz); only with SWDB_AUTOSCAN_EN
//
// PORTS
//   clk       in   1   system clock; all state on rising edge
//   rst_n     in   1   asynchronous, active-low reset
//   sw_in     in   4   raw async switches; sw_in[3]->a, [2]->b, [1]->c, [0]->d
//   scan_sel  in   1   1 = outputs from auto-scan counter (only with SWDB_AUTOSCAN_EN)
//   a         out  1   conditioned level, MSB of code {a,b,c,d}
//   b         out  1   conditioned level
//   c         out  1   conditioned level
//   d         out  1   conditioned level, LSB
//   changed   out  1   1-cycle pulse, high in the first cycle {a,b,c,d} shows a new value
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): sync flops, debounced bits, counters, scan state, a..d,
//     changed all 0. No changed pulse on reset release.
//   - Sync: 2-flop synchroniser per bit; s = second stage.
//   - Per channel i, each cycle:
//       s[i]==db[i]            -> cnt[i] <= 0 (bounce restarts the count)
//       s[i]!=db[i], cnt<CNT_MAX-1 -> cnt[i] <= cnt[i]+1
//       s[i]!=db[i], cnt==CNT_MAX-1 -> db[i] <= s[i], cnt[i] <= 0
//   - Latency: clean edge on sw_in appears on output after 2 + CNT_MAX cycles (+1 output reg).
//   - Glitch shorter than CNT_MAX cycles: no output change, no changed pulse.
//   - Channels independent; several may update in the same cycle -> single changed pulse.
//   - Outputs registered: {a,b,c,d} <= selected source; changed <= (next != current).
//   - Counters never overflow (cleared at CNT_MAX-1); no wrap-around possible.
//   - Reset asserted mid-count: count discarded; after release channel restarts from 0.
//
// CONFIGURATION
//   SWDB_AUTOSCAN_EN defined:
//     - 4-bit scan_code and divider; divider counts 0..SCAN_DIV-1, scan_code += 1 on wrap,
//       15 wraps to 0. Runs only while scan_sel=1; cleared to 0 when scan_sel=0.
//     - scan_sel=1: {a,b,c,d} <= scan_code; changed pulses each step.
//     - scan_sel 1->0: outputs return to debounced values next cycle; changed if different.
//     - Debouncers keep running regardless of scan_sel.
//   Not defined: scan_sel ignored (no logic), outputs always debounced values.
//
// TESTING  (bench uses CNT_MAX=4, SCAN_DIV=3)
//   1 rst_n=0 with sw_in=4'hF -> a..d=0, changed=0; release -> outputs 1111 after 2+4+1 cycles, one changed pulse.
//   2 sw_in[0] 0->1 held -> d=1 exactly 7 cycles after edge; changed high 1 cycle; a,b,c unchanged.
//   3 sw_in[2] toggled every 2 cycles for 20 cycles -> b stays 0, changed never asserts.
//   4 sw_in 0000->1010 same cycle -> a=1,c=1 same cycle, single changed pulse.
//   5 rst_n pulsed low at count 3 of sw_in[3] rising -> a=0; after release a=1 only 7 cycles later.
//   6 SWDB_AUTOSCAN_EN, scan_sel=1 for 50 cycles -> codes 0,1,..,15,0 every 3 cycles, changed per step;
//     scan_sel=0 with sw_in=0101 debounced -> outputs 0101 next cycle.

Source files
------------

// File: rtl/switch_debounce4.sv
// switch_debounce4: 2-flop synchroniser and per-channel debounce for four switches, with
// registered levels a..d and a one-cycle change strobe. Auto-scan mode under SWDB_AUTOSCAN_EN.
module switch_debounce4 #(
    parameter int unsigned CNT_MAX  = 12000,
    parameter int unsigned CNT_W    = 14,
    parameter int unsigned SCAN_DIV = 12000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_in,
    input  logic       scan_sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       changed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_db;
    logic [3:0]       w_db_d;
    logic [3:0]       w_src;
    logic [3:0]       r_out;
    logic             r_chg;
    logic [CNT_W-1:0] r_cnt   [4];
    logic [CNT_W-1:0] w_cnt_d [4];

    // Any sample matching the debounced level restarts that channel's count.
    always_comb begin
        w_db_d = r_db;
        for (int i = 0; i < 4; i++) begin
            w_cnt_d[i] = '0;
            if (r_sync2[i] != r_db[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_db_d[i] = r_sync2[i];
                end else begin
                    w_cnt_d[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_out   <= '0;
            r_chg   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            r_db    <= w_db_d;
            r_out   <= w_src;
            r_chg   <= (w_src != r_out);
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
        end
    end

`ifdef SWDB_AUTOSCAN_EN
    logic [DIV_W-1:0] r_scan_div;
    logic [3:0]       r_scan_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_div  <= '0;
            r_scan_code <= '0;
        end else if (!scan_sel) begin
            r_scan_div  <= '0;
            r_scan_code <= '0;
        end else if (r_scan_div == DIV_W'(SCAN_DIV - 1)) begin
            r_scan_div  <= '0;
            r_scan_code <= r_scan_code + 4'd1;
        end else begin
            r_scan_div  <= r_scan_div + 1'b1;
        end
    end

    assign w_src = scan_sel ? r_scan_code : r_db;
`else
    // scan_sel has no function in this build.
    logic [DIV_W:0] w_unused_cfg;
    assign w_unused_cfg = {scan_sel, {DIV_W{1'b0}}};
    assign w_src = r_db;
`endif

    assign {a, b, c, d} = r_out;
    assign changed      = r_chg;

endmodule

// File: tb/tb_switch_debounce4.sv
// Bench for switch_debounce4: directed and random stimulus against a sliding-window model.
module tb_switch_debounce4;

    localparam int unsigned CNT_MAX  = 4;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned SCAN_DIV = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_in;
    logic       scan_sel;
    logic       a, b, c, d, changed;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0]  swq[$];
    logic [3:0]  sq[$];
    logic [3:0]  m_db;
    logic [3:0]  m_out;
    logic        m_chg;
    int unsigned m_scan_k;

    switch_debounce4 #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_in   (sw_in),
        .scan_sel(scan_sel),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .changed (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        swq.delete();
        sq.delete();
        m_db     = 4'h0;
        m_out    = 4'h0;
        m_chg    = 1'b0;
        m_scan_k = 0;
    endfunction

    // A channel flips once its last CNT_MAX synchronised samples all disagree with it.
    function automatic void model_edge();
        logic [3:0] s_now;
        logic [3:0] src;
        logic [3:0] flip;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s_now = (swq.size() >= 2) ? swq[swq.size()-2] : 4'h0;
        swq.push_back(sw_in);
        if (swq.size() > 2) void'(swq.pop_front());
        sq.push_back(s_now);
        if (sq.size() > CNT_MAX) void'(sq.pop_front());
        src = m_db;
`ifdef SWDB_AUTOSCAN_EN
        if (scan_sel) begin
            src = 4'((m_scan_k / SCAN_DIV) % 16);
            m_scan_k++;
        end else begin
            m_scan_k = 0;
        end
`endif
        m_chg = (src != m_out);
        m_out = src;
        flip  = 4'hF;
        if (sq.size() < CNT_MAX) flip = 4'h0;
        else foreach (sq[j]) flip &= (sq[j] ^ m_db);
        m_db ^= flip;
    endfunction

    task automatic tick(input logic [3:0] sw, input logic rst_v, input logic sel);
        @(negedge clk);
        sw_in    = sw;
        rst_n    = rst_v;
        scan_sel = sel;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        int seen;
        int pulses;
        rst_n    = 1'b0;
        sw_in    = 4'hF;
        scan_sel = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({a, b, c, d, changed} !== 5'b0) begin
            bad++;
            $display("FAIL reset_state: got abcd=%b chg=%b, want 0000 0", {a, b, c, d}, changed);
        end
        seen   = -1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(4'hF, 1'b1, 1'b0);
            total++;
            if ({a, b, c, d} !== m_out || changed !== m_chg) begin
                bad++;
                $display("FAIL reset_release k=%0d: got %b/%b, want %b/%b",
                         k, {a, b, c, d}, changed, m_out, m_chg);
            end
            if (changed === 1'b1) pulses++;
            if (seen < 0 && {a, b, c, d} === 4'hF) seen = k;
        end
        total++;
        if (seen != 7) begin
            bad++;
            $display("FAIL reset_latency: got %0d cycles, want 7", seen);
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL reset_pulses: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_single_edge();
        int seen;
        int pulses;
        for (int k = 0; k < 10; k++) tick(4'h0, 1'b1, 1'b0);
        total++;
        if ({a, b, c, d} !== 4'h0) begin
            bad++;
            $display("FAIL single_settle: got %b, want 0000", {a, b, c, d});
        end
        seen   = -1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(4'h1, 1'b1, 1'b0);
            total++;
            if ({a, b, c, d} !== m_out || changed !== m_chg || {a, b, c} !== 3'b000) begin
                bad++;
                $display("FAIL single_edge k=%0d: got %b/%b, want %b/%b",
                         k, {a, b, c, d}, changed, m_out, m_chg);
            end
            if (changed === 1'b1) pulses++;
            if (seen < 0 && d === 1'b1) seen = k;
        end
        total++;
        if (seen != 7) begin
            bad++;
            $display("FAIL single_latency: got %0d cycles, want 7", seen);
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL single_pulses: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_glitch();
        int hits;
        for (int k = 0; k < 10; k++) tick(4'h0, 1'b1, 1'b0);
        hits = 0;
        for (int k = 0; k < 26; k++) begin
            tick((k < 20 && ((k / 2) % 2) == 1) ? 4'h4 : 4'h0, 1'b1, 1'b0);
            total++;
            if ({a, b, c, d} !== m_out || changed !== m_chg) begin
                bad++;
                $display("FAIL glitch_model k=%0d: got %b/%b, want %b/%b",
                         k, {a, b, c, d}, changed, m_out, m_chg);
            end
            if (b !== 1'b0 || changed !== 1'b0) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL glitch_quiet: got %0d active cycles, want 0", hits);
        end
    endtask

    task automatic test_multi();
        int          pulses;
        logic [3:0]  first;
        first  = 4'h0;
        pulses = 0;
        for (int k = 0; k < 10; k++) tick(4'h0, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick(4'hA, 1'b1, 1'b0);
            total++;
            if ({a, b, c, d} !== m_out || changed !== m_chg) begin
                bad++;
                $display("FAIL multi_model k=%0d: got %b/%b, want %b/%b",
                         k, {a, b, c, d}, changed, m_out, m_chg);
            end
            if (changed === 1'b1) pulses++;
            if (first == 4'h0 && {a, b, c, d} !== 4'h0) first = {a, b, c, d};
        end
        total++;
        if (first !== 4'hA) begin
            bad++;
            $display("FAIL multi_same_cycle: got first change %b, want 1010", first);
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL multi_pulses: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        for (int k = 0; k < 10; k++) tick(4'h0, 1'b1, 1'b0);
        // Edges 3..5 after the switch edge take the count to 3.
        for (int k = 0; k < 5; k++) tick(4'h8, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick(4'h8, 1'b0, 1'b0);
            total++;
            if ({a, b, c, d, changed} !== 5'b0) begin
                bad++;
                $display("FAIL mid_reset_hold: got %b/%b, want 0000/0", {a, b, c, d}, changed);
            end
        end
        seen = -1;
        for (int k = 1; k <= 12; k++) begin
            tick(4'h8, 1'b1, 1'b0);
            total++;
            if ({a, b, c, d} !== m_out || changed !== m_chg) begin
                bad++;
                $display("FAIL mid_model k=%0d: got %b/%b, want %b/%b",
                         k, {a, b, c, d}, changed, m_out, m_chg);
            end
            if (seen < 0 && a === 1'b1) seen = k;
        end
        total++;
        if (seen != 7) begin
            bad++;
            $display("FAIL mid_latency: got %0d cycles, want 7", seen);
        end
    endtask

    task automatic test_random();
        logic [3:0] pat;
        logic       sel;
        int         left;
        left = 0;
        pat  = 4'h0;
        sel  = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (left == 0) begin
                pat  = 4'($urandom_range(0, 15));
                left = $urandom_range(1, 8);
                sel  = ($urandom_range(0, 7) == 0);
            end
            left--;
            tick(pat, 1'b1, sel);
            total++;
            if ({a, b, c, d} !== m_out || changed !== m_chg) begin
                bad++;
                $display("FAIL random k=%0d: got %b/%b, want %b/%b",
                         k, {a, b, c, d}, changed, m_out, m_chg);
            end
        end
        for (int k = 0; k < 10; k++) tick(pat, 1'b1, 1'b0);
    endtask

`ifdef SWDB_AUTOSCAN_EN
    task automatic test_autoscan();
        int pulses;
        pulses = 0;
        for (int k = 0; k < 10; k++) tick(4'h5, 1'b1, 1'b0);
        for (int k = 1; k <= 50; k++) begin
            tick(4'h5, 1'b1, 1'b1);
            total++;
            if ({a, b, c, d} !== 4'(((k - 1) / 3) % 16) || changed !== m_chg) begin
                bad++;
                $display("FAIL scan_code k=%0d: got %b/%b, want %b/%b",
                         k, {a, b, c, d}, changed, 4'(((k - 1) / 3) % 16), m_chg);
            end
            if (changed === 1'b1) pulses++;
        end
        total++;
        if (pulses != 17) begin
            bad++;
            $display("FAIL scan_pulses: got %0d, want 17", pulses);
        end
        tick(4'h5, 1'b1, 1'b0);
        total++;
        if ({a, b, c, d} !== 4'h5 || changed !== 1'b1) begin
            bad++;
            $display("FAIL scan_exit: got %b/%b, want 0101/1", {a, b, c, d}, changed);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_edge();
        test_glitch();
        test_multi();
        test_reset_mid();
        test_random();
`ifdef SWDB_AUTOSCAN_EN
        test_autoscan();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
